// File: rtl/mult8x8_seq_ctrl_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller:
// FSM states, quadrant indices, per-quadrant shift amounts and combine modes.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] QLL = 2'd0;
  localparam logic [1:0] QLH = 2'd1;
  localparam logic [1:0] QHL = 2'd2;
  localparam logic [1:0] QHH = 2'd3;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_OR  = 1'b1;

  // Shift table {0,4,4,8} indexed by quadrant.
  function automatic logic [3:0] quad_shift(input logic [1:0] q);
    logic [3:0] s;
    case (q)
      QLL:     s = 4'd0;
      QLH:     s = 4'd4;
      QHL:     s = 4'd4;
      QHH:     s = 4'd8;
      default: s = 4'd0;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] combine(input logic [15:0] acc,
                                          input logic [15:0] part,
                                          input logic        mode);
    logic [15:0] res;
    if (mode == MODE_OR) begin
      res = acc | part;
    end else begin
      res = acc + part;
    end
    return res;
  endfunction

endpackage

// File: rtl/mult8x8_seq_ctrl_mul4x4_unit.sv
// Combinational 4x4 multiplier; when approx is set the TRUNC_BITS LSBs of the
// product are forced to zero.
module mul4x4_unit #(
  parameter int TRUNC_BITS = 2
) (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       approx,
  output logic [7:0] p
);

  localparam logic [7:0] TRUNC_MASK = 8'(8'hFF << TRUNC_BITS);

  logic [7:0] full_s;

  // Exact nibble product, optionally truncated.
  always_comb begin
    full_s = {4'h0, x} * {4'h0, y};
    if (approx) begin
      p = full_s & TRUNC_MASK;
    end else begin
      p = full_s;
    end
  end

endmodule

// File: rtl/mult8x8_seq_ctrl.sv
// Sequential 8x8 multiplier: one shared 4x4 unit walks the four nibble
// quadrants over four cycles, merging partials by add or OR.
module mult8x8_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int TRUNC_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        mode,
  input  logic [3:0]  quad_approx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] r,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        mode_q, mode_d;
  logic [3:0]  qa_q, qa_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] r_q, r_d;
  logic        out_valid_q, out_valid_d;

  logic [3:0]  x_s, y_s;
  logic [7:0]  p_s;
  logic [15:0] part_s;
  logic [15:0] sum_s;

  // Select the operand nibbles for the quadrant being processed.
  always_comb begin
    case (cnt_q)
      QLL:     begin x_s = a_q[3:0]; y_s = b_q[3:0]; end
      QLH:     begin x_s = a_q[3:0]; y_s = b_q[7:4]; end
      QHL:     begin x_s = a_q[7:4]; y_s = b_q[3:0]; end
      QHH:     begin x_s = a_q[7:4]; y_s = b_q[7:4]; end
      default: begin x_s = 4'h0;     y_s = 4'h0;     end
    endcase
  end

  mul4x4_unit #(.TRUNC_BITS(TRUNC_BITS)) u_mul (
    .x      (x_s),
    .y      (y_s),
    .approx (qa_q[cnt_q]),
    .p      (p_s)
  );

  // Align the partial product and merge it into the accumulator.
  always_comb begin
    part_s = {8'h00, p_s} << quad_shift(cnt_q);
    sum_s  = combine(acc_q, part_s, mode_q);
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign r         = r_q;

  // Next-state and datapath update logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    qa_d        = qa_q;
    acc_d       = acc_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          qa_d    = quad_approx;
          acc_d   = 16'h0000;
          cnt_d   = 2'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = sum_s;
        r_d   = sum_s;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == QHH) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      mode_q      <= MODE_ADD;
      qa_q        <= 4'h0;
      acc_q       <= 16'h0000;
      r_q         <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      qa_q        <= qa_d;
      acc_q       <= acc_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Scoreboard bench for mult8x8_seq_ctrl: directed requests push expected
// results; a monitor pops and compares on every output handshake.
module tb_mult8x8_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        mode;
  logic [3:0]  quad_approx;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] r;
  logic        busy;

  int errors;
  int checks;
  logic [15:0] exp_q[$];

  mult8x8_seq_ctrl #(.TRUNC_BITS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .mode        (mode),
    .quad_approx (quad_approx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .r           (r),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got r=%0h expected no output", r);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (r !== e) begin
          errors++;
          $display("FAIL result: got r=%0h expected %0h", r, e);
        end
      end
    end
  end

  // Present a request, wait for the accept edge, and check the 4-cycle latency.
  task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic mi,
                       input logic [3:0] qi, input logic [15:0] exp, input bit push);
    int cyc;
    a = ai; b = bi; mode = mi; quad_approx = qi; in_valid = 1'b1;
    #1;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20 && !rst) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < 4) check("in_ready_in_run", {31'd0, in_ready}, 32'd0);
    end
    if (push) check("latency", cyc, 32'd4);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; mode = 1'b0;
    quad_approx = 4'h0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_in_ready_after", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_r", {16'd0, r}, 32'h0000);
    check("reset_busy", {31'd0, busy}, 32'd0);

    issue(8'hFF, 8'hFF, 1'b0, 4'h0, 16'hFE01, 1'b1);
    wait_idle();
    issue(8'hFF, 8'hFF, 1'b1, 4'h0, 16'hEFF1, 1'b1);
    wait_idle();
    issue(8'hFF, 8'hFF, 1'b0, 4'hF, 16'hFCE0, 1'b1);
    wait_idle();
    issue(8'hA5, 8'h3C, 1'b0, 4'h0, 16'h26AC, 1'b1);
    wait_idle();

    // Consumer stall for three cycles in DONE.
    out_ready = 1'b0;
    issue(8'h03, 8'h05, 1'b0, 4'h0, 16'h000F, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_r", {16'd0, r}, 32'h000F);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_handshake_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_handshake_out_valid", {31'd0, out_valid}, 32'd0);

    // Inputs toggle during RUN; only the latched operands count.
    a = 8'h10; b = 8'h10; mode = 1'b0; quad_approx = 4'h0; in_valid = 1'b1;
    #1;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(16'h0100);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      a = 8'hFF ^ a; b = 8'h5A ^ b; mode = ~mode; quad_approx = ~quad_approx;
      in_valid = 1'b1;
      @(posedge clk);
    end
    #1;
    check("toggle_out_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("toggle_no_second_accept", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("toggle_still_idle", {31'd0, busy}, 32'd0);

    // Reset during RUN at cnt=2 discards the operation.
    a = 8'hFF; b = 8'hFF; mode = 1'b0; quad_approx = 4'h0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_r", {16'd0, r}, 32'h0000);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    issue(8'h02, 8'h07, 1'b0, 4'h0, 16'h000E, 1'b1);
    wait_idle();

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
